ib_counter_check: RTL and testbench

//   Receive-side checker for a free-running up-counter stream such as ib_counter_16.o_c.

---
 rtl/ib_counter_check.sv | 176 +++++++++++++++++
 tb/tb_ib_counter_check.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ib_counter_check.sv
`default_nettype none
// ============================================================================
// Module   : ib_counter_check
// Purpose  : Receive-side checker for a free-running up-counter stream.
//            Each qualified sample must equal the previous sample + 1
//            (mod 2^W). LOCK_N consecutive good increments declare lock;
//            a discontinuity while locked is flagged, counted (saturating)
//            and the checker falls back to acquisition to relock.
// Ports    : i_clk        clock, rising edge
//            i_rst        synchronous reset, active high
//            i_valid      i_c holds a sample this cycle
//            i_c [W]      counter value under check
//            o_locked     stream verified contiguous
//            o_err        sticky: a mismatch was seen while locked
//            o_err_pulse  one-cycle strobe per mismatch while locked
//            o_err_cnt    saturating count of mismatches while locked
//            o_cap_exp/o_cap_act [W]  (IB_COUNTER_CHECK_CAPTURE_EN only)
//                         expected/actual value of the first locked mismatch
// Config   : `define IB_COUNTER_CHECK_CAPTURE_EN adds the capture outputs.
// Revision : 1.0  initial release
// ============================================================================
module ib_counter_check #(
    parameter int W      = 16,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [W-1:0]     i_c,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_err_pulse,
    output logic [ERR_W-1:0] o_err_cnt
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
    ,
    output logic [W-1:0]     o_cap_exp,
    output logic [W-1:0]     o_cap_act
`endif
);

    // Wide enough to hold LOCK_N itself; in LOCK the counter parks at LOCK_N.
    localparam int c_GOOD_W = $clog2(LOCK_N + 1);
    localparam logic [c_GOOD_W-1:0] c_LOCK_N = c_GOOD_W'(LOCK_N);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACQ  = 2'd1;
    localparam logic [1:0] c_LOCK = 2'd2;

    logic [1:0]          r_state_q,     w_state_d;
    logic [W-1:0]        r_prev_q,      w_prev_d;
    logic [c_GOOD_W-1:0] r_good_q,      w_good_d;
    logic                r_locked_q,    w_locked_d;
    logic                r_err_q,       w_err_d;
    logic                r_err_pulse_q, w_err_pulse_d;
    logic [ERR_W-1:0]    r_err_cnt_q,   w_err_cnt_d;
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
    logic [W-1:0]        r_cap_exp_q,   w_cap_exp_d;
    logic [W-1:0]        r_cap_act_q,   w_cap_act_d;
`endif

    logic [W-1:0]        w_prev_inc;
    logic [c_GOOD_W-1:0] w_good_inc;
    logic                w_match;
    logic                w_lock_miss;

    // Increment is taken in W bits so the wrap 2^W-1 -> 0 counts as a match.
    assign w_prev_inc  = r_prev_q + W'(1);
    assign w_good_inc  = r_good_q + c_GOOD_W'(1);
    assign w_match     = (i_c == w_prev_inc);
    assign w_lock_miss = i_valid && (r_state_q == c_LOCK) && !w_match;

    // ------------------------------------------------------------------
    // State register (all flops)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q     <= c_IDLE;
            r_prev_q      <= '0;
            r_good_q      <= '0;
            r_locked_q    <= 1'b0;
            r_err_q       <= 1'b0;
            r_err_pulse_q <= 1'b0;
            r_err_cnt_q   <= '0;
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
            r_cap_exp_q   <= '0;
            r_cap_act_q   <= '0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_prev_q      <= w_prev_d;
            r_good_q      <= w_good_d;
            r_locked_q    <= w_locked_d;
            r_err_q       <= w_err_d;
            r_err_pulse_q <= w_err_pulse_d;
            r_err_cnt_q   <= w_err_cnt_d;
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
            r_cap_exp_q   <= w_cap_exp_d;
            r_cap_act_q   <= w_cap_act_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: advances on valid samples only
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_good_d  = r_good_q;
        w_prev_d  = r_prev_q;
        if (i_valid) begin
            // Every sample becomes the new reference, so relock counts
            // from the mismatching value itself.
            w_prev_d = i_c;
            case (r_state_q)
                c_IDLE: begin
                    w_good_d  = '0;
                    w_state_d = c_ACQ;
                end
                c_ACQ: begin
                    if (w_match) begin
                        w_good_d = w_good_inc;
                        if (w_good_inc == c_LOCK_N) begin
                            w_state_d = c_LOCK;
                        end
                    end else begin
                        w_good_d = '0;
                    end
                end
                c_LOCK: begin
                    if (!w_match) begin
                        w_good_d  = '0;
                        w_state_d = c_ACQ;
                    end
                end
                default: begin
                    w_good_d  = '0;
                    w_state_d = c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_locked_d    = (w_state_d == c_LOCK);
        w_err_d       = r_err_q | w_lock_miss;
        w_err_pulse_d = w_lock_miss;
        w_err_cnt_d   = r_err_cnt_q;
        if (w_lock_miss && !(&r_err_cnt_q)) begin
            w_err_cnt_d = r_err_cnt_q + ERR_W'(1);
        end
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
        w_cap_exp_d = r_cap_exp_q;
        w_cap_act_d = r_cap_act_q;
        // Sticky error still clear means this is the first locked mismatch.
        if (w_lock_miss && !r_err_q) begin
            w_cap_exp_d = w_prev_inc;
            w_cap_act_d = i_c;
        end
`endif
    end

    assign o_locked    = r_locked_q;
    assign o_err       = r_err_q;
    assign o_err_pulse = r_err_pulse_q;
    assign o_err_cnt   = r_err_cnt_q;
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
    assign o_cap_exp   = r_cap_exp_q;
    assign o_cap_act   = r_cap_act_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ib_counter_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_ib_counter_check
// Purpose  : Self-checking bench for ib_counter_check. Two instances share
//            the same stimulus: one with default parameters and one with
//            ERR_W=2 to exercise error-counter saturation. Each stimulus
//            step queues its hand-computed expectation; a monitor on the
//            falling edge pops and compares against the registered outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_ib_counter_check;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [15:0] c;

    logic        locked_a, err_a, pulse_a;
    logic [15:0] cnt_a;
    logic        locked_b, err_b, pulse_b;
    logic [1:0]  cnt_b;
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
    logic [15:0] cap_exp_a, cap_act_a, cap_exp_b, cap_act_b;
`endif

    ib_counter_check #(.W(16), .LOCK_N(4), .ERR_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_c(c),
        .o_locked(locked_a), .o_err(err_a), .o_err_pulse(pulse_a),
        .o_err_cnt(cnt_a)
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
        , .o_cap_exp(cap_exp_a), .o_cap_act(cap_act_a)
`endif
    );

    ib_counter_check #(.W(16), .LOCK_N(4), .ERR_W(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_c(c),
        .o_locked(locked_b), .o_err(err_b), .o_err_pulse(pulse_b),
        .o_err_cnt(cnt_b)
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
        , .o_cap_exp(cap_exp_b), .o_cap_act(cap_act_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        l;
        logic        e;
        logic        p;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic [15:0] cx;
        logic [15:0] ca;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    string       cur_tag  = "reset";
    logic [15:0] cur_cx   = 16'h0;
    logic [15:0] cur_ca   = 16'h0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endfunction

    // Monitor: outputs are stable mid-cycle, after the edge that produced them.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, " locked"},     {31'd0, locked_a}, {31'd0, e.l});
            chk({e.tag, " err"},        {31'd0, err_a},    {31'd0, e.e});
            chk({e.tag, " pulse"},      {31'd0, pulse_a},  {31'd0, e.p});
            chk({e.tag, " err_cnt"},    {16'd0, cnt_a},    {16'd0, e.cnt});
            chk({e.tag, " sat locked"}, {31'd0, locked_b}, {31'd0, e.l});
            chk({e.tag, " sat pulse"},  {31'd0, pulse_b},  {31'd0, e.p});
            chk({e.tag, " sat err_cnt"},{30'd0, cnt_b},    {30'd0, e.cnt2});
`ifdef IB_COUNTER_CHECK_CAPTURE_EN
            chk({e.tag, " cap_exp"},    {16'd0, cap_exp_a}, {16'd0, e.cx});
            chk({e.tag, " cap_act"},    {16'd0, cap_act_a}, {16'd0, e.ca});
`endif
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after its edge.
    task automatic step(input logic r, input logic v, input logic [15:0] cv,
                        input logic el, input logic ee, input logic ep,
                        input int ecnt);
        exp_t e;
        rst   = r;
        valid = v;
        c     = cv;
        @(posedge clk);
        #1;
        e.l    = el;
        e.e    = ee;
        e.p    = ep;
        e.cnt  = 16'(ecnt);
        e.cnt2 = (ecnt > 3) ? 2'd3 : 2'(ecnt);
        e.cx   = cur_cx;
        e.ca   = cur_ca;
        e.tag  = cur_tag;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        cur_cx = 16'h0;
        cur_ca = 16'h0;
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        c     = 16'h0;

        // Reset state, and reset beating a simultaneous valid sample
        cur_tag = "reset";
        do_reset();
        step(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 0);

        // Test 1: 0..4 locks after the edge sampling 4
        cur_tag = "t1_lock";
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 0);

        // Test 2: lock near the top, then wrap through 0xFFFF -> 0x0000
        cur_tag = "t2_wrap";
        do_reset();
        step(1'b0, 1'b1, 16'hFFF8, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'hFFF9, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'hFFFA, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'hFFFC, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'hFFFD, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 0);

        // Test 4: gaps of 1..3 invalid cycles carrying junk stay locked
        cur_tag = "t4_gaps";
        step(1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 16'hA5A5, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 16'hA5A5, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'hA5A5, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 0);

        // Test 3: locked at 0x10, skip to 0x12, relock after 0x16
        cur_tag = "t3_skip";
        do_reset();
        step(1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h000D, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 0);
        cur_cx = 16'h0011;
        cur_ca = 16'h0012;
        step(1'b0, 1'b1, 16'h0012, 1'b0, 1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 16'h0013, 1'b0, 1'b1, 1'b0, 1);
        step(1'b0, 1'b1, 16'h0014, 1'b0, 1'b1, 1'b0, 1);
        step(1'b0, 1'b1, 16'h0015, 1'b0, 1'b1, 1'b0, 1);
        step(1'b0, 1'b1, 16'h0016, 1'b1, 1'b1, 1'b0, 1);

        // Test 6: five lock/mismatch rounds; ERR_W=2 instance saturates at 3
        cur_tag = "t6_sat";
        do_reset();
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 0);
        cur_cx = 16'h0005;
        cur_ca = 16'h1000;
        for (int k = 0; k < 5; k++) begin
            logic [15:0] m;
            m = 16'h1000 * 16'(k + 1);
            step(1'b0, 1'b1, m, 1'b0, 1'b1, 1'b1, k + 1);
            if (k == 2) begin
                // A mismatch while acquiring is neither pulsed nor counted
                m = m + 16'h0010;
                step(1'b0, 1'b1, m, 1'b0, 1'b1, 1'b0, k + 1);
            end
            step(1'b0, 1'b1, m + 16'd1, 1'b0, 1'b1, 1'b0, k + 1);
            step(1'b0, 1'b1, m + 16'd2, 1'b0, 1'b1, 1'b0, k + 1);
            step(1'b0, 1'b1, m + 16'd3, 1'b0, 1'b1, 1'b0, k + 1);
            step(1'b0, 1'b1, m + 16'd4, 1'b1, 1'b1, 1'b0, k + 1);
        end

        // Test 5: reset while locked with sticky error clears everything
        cur_tag = "t5_rst";
        cur_cx = 16'h0;
        cur_ca = 16'h0;
        step(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);

        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
